// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// InstrSequencer (module instr_sequencer)
//
// Purpose:
//    Multi-cycle instruction sequencer. Each instruction goes through four
//    phases: FETCH, WAIT, EXEC and WB. In FETCH the fetch request is raised.
//    In WAIT the instruction word is captured when memory acknowledges. In
//    EXEC the operands are presented to an external execute stage and a
//    one-cycle strobe is pulsed. In WB the results are written back and the
//    PC is advanced or redirected. Decoding HALT_OP parks the sequencer in
//    HALT until the next reset.
//
// Instruction word layout:
//    [31:25] opcode, [24:21] rd, [20:17] rs1, [16:13] rs2,
//    [16] highlow, [15:0] value
//
// Ports:
//    clock        in   1   sole clock, rising edge
//    reset_n      in   1   asynchronous active-low reset
//    mem_req      out  1   fetch request, held until acknowledged
//    mem_addr     out  32  word address of the fetch (the PC)
//    mem_ack      in   1   fetch data valid, honoured only while mem_req=1
//    mem_rdata    in   32  instruction word
//    alu_A        out  32  register-file read of rs1
//    alu_B        out  32  register-file read of rs2
//    alu_reg8     out  32  register-file read of register 8
//    alu_value    out  16  immediate field
//    alu_highlow  out  1   load-half select
//    alu_instr    out  7   opcode of the instruction register
//    alu_clock    out  1   execute strobe, one cycle per instruction
//    alu_C        in   32  execute result
//    alu_F3       in   1   compare/branch flag result
//    alu_addrch   in   1   redirect request
//    alu_naddr    in   32  redirect target
//    F1, F2       out  1   flag registers fed back to the execute stage
//    halted       out  1   high once HALT_OP has been decoded
// ---------------------------------------------------------------------------
module instr_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [6:0]  HALT_OP  = 7'd127
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] alu_A,
   output logic [31:0] alu_B,
   output logic [31:0] alu_reg8,
   output logic [15:0] alu_value,
   output logic        alu_highlow,
   output logic [6:0]  alu_instr,
   output logic        alu_clock,
   input  logic [31:0] alu_C,
   input  logic        alu_F3,
   input  logic        alu_addrch,
   input  logic [31:0] alu_naddr,
   output logic        F1,
   output logic        F2,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_WAIT,
      S_EXEC,
      S_WB,
      S_HALT
   } stateT;

   stateT       state_q;
   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic        memReq_q;
   logic        aluClock_q;
   logic        f1_q;
   logic        f2_q;
   logic        halted_q;

   logic [31:0] cSample_q;
   logic        f3Sample_q;
   logic        addrchSample_q;
   logic [31:0] naddrSample_q;

   logic [31:0] regFile_q [16];

   logic [6:0]  opcode;
   logic [3:0]  rdIdx;
   logic [3:0]  rs1Idx;
   logic [3:0]  rs2Idx;
   logic        isHalt;
   logic        isRegWrite;
   logic        isFlagOp;
   logic [31:0] pcNext_d;
   logic        regWrite_d;

   // Field extraction from the instruction register. The rs2 index and the
   // highlow/value fields overlap on purpose; the execute stage decides
   // which interpretation applies to a given opcode.
   assign opcode = ir_q[31:25];
   assign rdIdx  = ir_q[24:21];
   assign rs1Idx = ir_q[20:17];
   assign rs2Idx = ir_q[16:13];

   // Opcode classes. HALT_OP is a parameter and could in principle collide
   // with the write-back or flag ranges, so halt takes precedence and
   // suppresses every other write-back effect.
   always_comb begin
      isHalt     = (opcode == HALT_OP);
      isRegWrite = (opcode <= 7'd7) && !isHalt;
      isFlagOp   = (opcode >= 7'd8) && (opcode <= 7'd13) && !isHalt;
   end

   // Next PC from the values sampled at the end of EXEC: either the
   // redirect target or the sequential successor, which wraps naturally
   // at 2^32 because the adder is exactly 32 bits wide.
   always_comb begin
      pcNext_d   = addrchSample_q ? naddrSample_q : (pc_q + 32'd1);
      regWrite_d = (state_q == S_WB) && isRegWrite;
   end

   // Sequencer FSM with all control outputs registered. mem_req rises on
   // the first edge after reset release and drops on the edge that captures
   // the instruction, so an acknowledge outside that window is never seen.
   // alu_clock is raised on the same capture edge and dropped one cycle
   // later, giving exactly one strobe per instruction. The execute results
   // are latched on the EXEC closing edge so that WB works on stable data
   // regardless of what the execute stage drives afterwards.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_FETCH;
         pc_q           <= RESET_PC;
         ir_q           <= '0;
         memReq_q       <= 1'b0;
         aluClock_q     <= 1'b0;
         f1_q           <= 1'b0;
         f2_q           <= 1'b0;
         halted_q       <= 1'b0;
         cSample_q      <= '0;
         f3Sample_q     <= 1'b0;
         addrchSample_q <= 1'b0;
         naddrSample_q  <= '0;
      end else begin
         case (state_q)
            S_FETCH: begin
               memReq_q <= 1'b1;
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               if (memReq_q && mem_ack) begin
                  ir_q       <= mem_rdata;
                  memReq_q   <= 1'b0;
                  aluClock_q <= 1'b1;
                  state_q    <= S_EXEC;
               end
            end
            S_EXEC: begin
               aluClock_q     <= 1'b0;
               cSample_q      <= alu_C;
               f3Sample_q     <= alu_F3;
               addrchSample_q <= alu_addrch;
               naddrSample_q  <= alu_naddr;
               state_q        <= S_WB;
            end
            S_WB: begin
               if (isHalt) begin
                  halted_q <= 1'b1;
                  state_q  <= S_HALT;
               end else begin
                  if (isFlagOp) begin
                     f2_q <= f1_q;
                     f1_q <= f3Sample_q;
                  end
                  pc_q    <= pcNext_d;
                  state_q <= S_FETCH;
               end
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: begin
               state_q <= S_FETCH;
            end
         endcase
      end
   end

   // Register file: cleared on reset, single synchronous write port that is
   // only active on the WB closing edge. Reads happen in EXEC and WB, never
   // on the same edge as a write, so no read/write bypass is needed.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) begin
            regFile_q[i] <= '0;
         end
      end else if (regWrite_d) begin
         regFile_q[rdIdx] <= cSample_q;
      end
   end

   // Operand and status outputs. Operands come straight from IR and the
   // register file; both are frozen from entry to EXEC through WB, which
   // keeps the execute stage inputs stable for the whole instruction.
   assign mem_req     = memReq_q;
   assign mem_addr    = pc_q;
   assign alu_A       = regFile_q[rs1Idx];
   assign alu_B       = regFile_q[rs2Idx];
   assign alu_reg8    = regFile_q[8];
   assign alu_value   = ir_q[15:0];
   assign alu_highlow = ir_q[16];
   assign alu_instr   = opcode;
   assign alu_clock   = aluClock_q;
   assign F1          = f1_q;
   assign F2          = f2_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// TbInstrSequencer (module tb_instr_sequencer)
//
// Purpose:
//    Self-checking bench for instr_sequencer. The bench plays both the
//    instruction memory and the execute stage. An instruction-level model
//    (register array, PC, IR, flags) tracks what the outputs must be, and a
//    single compare process checks every output against it on each falling
//    clock edge. Directed sequences with literal expectations pin the model;
//    a randomized sequence then exercises opcodes, fetch latencies,
//    redirects and spurious acknowledges.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [6:0]  HALT_OP  = 7'd127;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] alu_A;
   logic [31:0] alu_B;
   logic [31:0] alu_reg8;
   logic [15:0] alu_value;
   logic        alu_highlow;
   logic [6:0]  alu_instr;
   logic        alu_clock;
   logic [31:0] alu_C;
   logic        alu_F3;
   logic        alu_addrch;
   logic [31:0] alu_naddr;
   logic        F1;
   logic        F2;
   logic        halted;

   logic [31:0] mRegs [16];
   logic [31:0] mPc;
   logic [31:0] mIr;
   logic        mF1;
   logic        mF2;
   logic        mHalted;
   logic        expReq;
   logic        expClk;
   logic        checkEn = 1'b0;

   int total = 0;
   int bad   = 0;

   instr_sequencer #(
      .RESET_PC (RESET_PC),
      .HALT_OP  (HALT_OP)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .alu_A       (alu_A),
      .alu_B       (alu_B),
      .alu_reg8    (alu_reg8),
      .alu_value   (alu_value),
      .alu_highlow (alu_highlow),
      .alu_instr   (alu_instr),
      .alu_clock   (alu_clock),
      .alu_C       (alu_C),
      .alu_F3      (alu_F3),
      .alu_addrch  (alu_addrch),
      .alu_naddr   (alu_naddr),
      .F1          (F1),
      .F2          (F2),
      .halted      (halted)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Builds an instruction word from opcode, rd, rs1 and the low 17 bits
   // (rs2/highlow/value share those bits).
   function automatic logic [31:0] mk(input logic [6:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1,
                                      input logic [16:0] low);
      return {op, rd, rs1, low};
   endfunction

   // Model state after reset: everything cleared, PC at RESET_PC, no request.
   task automatic modelReset();
      for (int i = 0; i < 16; i++) begin
         mRegs[i] = '0;
      end
      mPc     = RESET_PC;
      mIr     = '0;
      mF1     = 1'b0;
      mF2     = 1'b0;
      mHalted = 1'b0;
      expReq  = 1'b0;
      expClk  = 1'b0;
   endtask

   // Compare process: every falling edge, every output against the model.
   // Operand expectations are derived from the model IR and register array.
   always @(negedge clock) begin
      if (checkEn) begin
         checkOutput("mem_req",     32'(mem_req),     32'(expReq));
         checkOutput("mem_addr",    mem_addr,         mPc);
         checkOutput("alu_clock",   32'(alu_clock),   32'(expClk));
         checkOutput("halted",      32'(halted),      32'(mHalted));
         checkOutput("F1",          32'(F1),          32'(mF1));
         checkOutput("F2",          32'(F2),          32'(mF2));
         checkOutput("alu_instr",   32'(alu_instr),   32'(mIr[31:25]));
         checkOutput("alu_A",       alu_A,            mRegs[mIr[20:17]]);
         checkOutput("alu_B",       alu_B,            mRegs[mIr[16:13]]);
         checkOutput("alu_reg8",    alu_reg8,         mRegs[8]);
         checkOutput("alu_value",   32'(alu_value),   32'(mIr[15:0]));
         checkOutput("alu_highlow", 32'(alu_highlow), 32'(mIr[16]));
      end
   end

   // Runs one instruction. Entry: just after a rising edge with the DUT in
   // FETCH. Exit: just after the edge that leaves WB. junkAck drives an
   // acknowledge with garbage data during FETCH, which must be ignored.
   task automatic applyStimulus(input logic [31:0] instr, input int delay,
                                input logic [31:0] c, input logic f3,
                                input logic ach, input logic [31:0] naddr,
                                input logic junkAck);
      logic [6:0] op;
      op = instr[31:25];
      if (junkAck) begin
         mem_ack   = 1'b1;
         mem_rdata = $urandom;
      end
      @(posedge clock); #1;
      mem_ack = 1'b0;
      expReq  = 1'b1;
      repeat (delay) begin
         @(posedge clock); #1;
      end
      mem_ack   = 1'b1;
      mem_rdata = instr;
      @(posedge clock); #1;
      mem_ack    = 1'b0;
      mem_rdata  = $urandom;
      mIr        = instr;
      expReq     = 1'b0;
      expClk     = 1'b1;
      alu_C      = c;
      alu_F3     = f3;
      alu_addrch = ach;
      alu_naddr  = naddr;
      @(posedge clock); #1;
      expClk     = 1'b0;
      alu_C      = $urandom;
      alu_F3     = 1'($urandom);
      alu_addrch = 1'($urandom);
      alu_naddr  = $urandom;
      @(posedge clock); #1;
      if (op == HALT_OP) begin
         mHalted = 1'b1;
      end else begin
         if (op <= 7'd7) begin
            mRegs[instr[24:21]] = c;
         end else if (op <= 7'd13) begin
            mF2 = mF1;
            mF1 = f3;
         end
         mPc = ach ? naddr : mPc + 32'd1;
      end
   endtask

   // Asynchronous reset pulse placed between edges; leaves the bench just
   // after a rising edge with the DUT in FETCH.
   task automatic pulseReset();
      @(posedge clock); #2;
      reset_n = 1'b0;
      modelReset();
      @(posedge clock); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, bench did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [6:0]  op;
      logic [31:0] r;
      reset_n    = 1'b0;
      mem_ack    = 1'b0;
      mem_rdata  = '0;
      alu_C      = '0;
      alu_F3     = 1'b0;
      alu_addrch = 1'b0;
      alu_naddr  = '0;
      modelReset();
      checkEn = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rst_mem_req",   32'(mem_req),   32'd0);
      checkOutput("rst_mem_addr",  mem_addr,       32'h0000_0000);
      checkOutput("rst_alu_clock", 32'(alu_clock), 32'd0);
      reset_n = 1'b1;

      // Simple write: R1 <= 5, sequential PC.
      applyStimulus(mk(7'd0, 4'd1, 4'd0, 17'h0), 0, 32'd5, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("lit_pc_after_first", mem_addr, 32'd1);

      // Slow memory, R8 <= 0x1234 reading R1 as rs1.
      applyStimulus(mk(7'd0, 4'd8, 4'd1, 17'h0), 3, 32'h1234, 1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("lit_r1_via_alu_A", alu_A, 32'd5);
      checkOutput("lit_r8", alu_reg8, 32'h1234);
      checkOutput("lit_pc_after_second", mem_addr, 32'd2);

      // Flag opcodes shift F1 into F2 and must not write rd (rd=8 here).
      applyStimulus(mk(7'd8, 4'd8, 4'd0, 17'h0), 0, 32'hDEAD, 1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("lit_F1_op8", 32'(F1), 32'd1);
      checkOutput("lit_F2_op8", 32'(F2), 32'd0);
      applyStimulus(mk(7'd9, 4'd8, 4'd0, 17'h0), 1, 32'hBEEF, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("lit_F1_op9", 32'(F1), 32'd0);
      checkOutput("lit_F2_op9", 32'(F2), 32'd1);
      checkOutput("lit_r8_unchanged", alu_reg8, 32'h1234);

      // Redirect taken and not taken.
      applyStimulus(mk(7'd14, 4'd2, 4'd0, 17'h0), 0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0);
      checkOutput("lit_branch_taken", mem_addr, 32'h40);
      applyStimulus(mk(7'd14, 4'd2, 4'd0, 17'h0), 0, 32'h0, 1'b0, 1'b0, 32'h80, 1'b0);
      checkOutput("lit_branch_not_taken", mem_addr, 32'h41);

      // PC wrap from FFFF_FFFF to 0.
      applyStimulus(mk(7'd14, 4'd0, 4'd0, 17'h0), 0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      checkOutput("lit_pc_max", mem_addr, 32'hFFFF_FFFF);
      applyStimulus(mk(7'd3, 4'd3, 4'd0, 17'h0), 2, 32'h77, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("lit_pc_wrap", mem_addr, 32'h0);

      // Randomized instruction stream (never the halt opcode).
      for (int n = 0; n < 80; n++) begin
         op = 7'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) begin
            op = 7'($urandom_range(16, 126));
         end
         r = $urandom;
         applyStimulus({op, r[24:0]}, $urandom_range(0, 3), $urandom,
                       1'($urandom), ($urandom_range(0, 3) == 0), $urandom,
                       1'($urandom));
      end

      // Reset in the middle of WAIT abandons the fetch; a late acknowledge
      // while mem_req is low must be ignored.
      @(posedge clock); #1;
      expReq = 1'b1;
      @(posedge clock); #2;
      reset_n = 1'b0;
      modelReset();
      #1;
      checkOutput("lit_midwait_rst_req", 32'(mem_req), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      checkOutput("lit_midwait_rst_pc", mem_addr, RESET_PC);
      applyStimulus(mk(7'd2, 4'd5, 4'd0, 17'h0), 1, 32'h55, 1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("lit_after_abort_pc", mem_addr, 32'd1);

      // Halt: no further requests, then a reset pulse restarts fetching.
      applyStimulus(mk(7'd127, 4'd4, 4'd0, 17'h0), 0, 32'h99, 1'b1, 1'b1, 32'h300, 1'b0);
      for (int k = 0; k < 20; k++) begin
         mem_ack = 1'($urandom);
         @(posedge clock); #1;
      end
      mem_ack = 1'b0;
      checkOutput("lit_halted", 32'(halted), 32'd1);
      checkOutput("lit_halt_req", 32'(mem_req), 32'd0);
      checkOutput("lit_halt_pc", mem_addr, 32'd1);
      pulseReset();
      checkOutput("lit_halt_cleared", 32'(halted), 32'd0);
      checkOutput("lit_restart_pc", mem_addr, RESET_PC);
      applyStimulus(mk(7'd1, 4'd6, 4'd0, 17'h0), 0, 32'h66, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("lit_restart_next_pc", mem_addr, RESET_PC + 32'd1);

      @(posedge clock); #1;
      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, word address of the first fetch after reset.
REQ-002 SHALL have parameter HALT_OP, default 7'd127, opcode that stops sequencing.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 mem_req  out  1  instruction fetch request, held until accepted.
REQ-007 mem_addr  out  32  word address of the fetch (PC).
REQ-008 mem_ack  in  1  fetch data valid; accepted only while mem_req=1.
REQ-009 mem_rdata  in  32  instruction word.
REQ-010 alu_A, alu_B, alu_reg8  out  32 each  register-file operands: rs1, rs2 and register 8.
REQ-011 alu_value  out  16  immediate field; alu_highlow  out  1  load-half select.
REQ-012 alu_instr  out  7  opcode to execute stage.
REQ-013 alu_clock  out  1  execute strobe, high for exactly one cycle per instruction.
REQ-014 alu_C  in  32  execute result; alu_F3  in  1  compare/branch flag result.
REQ-015 alu_addrch  in  1  redirect request; alu_naddr  in  32  redirect target.
REQ-016 F1, F2  out  1 each  flag registers fed back to execute stage.
REQ-017 halted  out  1  high once HALT_OP has been decoded.

Function
REQ-018 Instruction format SHALL be: [31:25] opcode, [24:21] rd, [20:17] rs1, [16:13] rs2, [16] highlow, [15:0] value.
REQ-019 Register file SHALL be 16 x 32 bits; 2 combinational read ports (rs1, rs2) plus a dedicated register-8 read; 1 synchronous write port.
REQ-020 FSM states SHALL be FETCH, WAIT, EXEC, WB, HALT; encoding is free.
REQ-021 FETCH: assert mem_req with mem_addr=PC, go to WAIT next cycle.
REQ-022 WAIT: hold mem_req and mem_addr; on mem_ack capture mem_rdata into IR, go to EXEC; otherwise stay.
REQ-023 EXEC: drive operands from IR, assert alu_clock for this one cycle, sample alu_C, alu_F3, alu_addrch, alu_naddr at the closing edge, go to WB.
REQ-024 WB: opcodes 0-7 SHALL write the sampled C into rd; opcodes 8-13 SHALL set F2<=F1, F1<=sampled F3; all other opcodes SHALL write nothing.
REQ-025 WB: PC SHALL become sampled naddr when sampled addrch=1, else PC+1 (mod 2^32, FFFF_FFFF wraps to 0); then go to FETCH.
REQ-026 Decoding HALT_OP in WB SHALL go to HALT, set halted=1, leave PC unchanged; HALT is left only by reset.
REQ-027 alu_A/alu_B/alu_reg8/alu_value/alu_highlow/alu_instr SHALL be stable from entry to EXEC through WB.
REQ-028 Outside EXEC, alu_clock SHALL be 0; alu_instr SHALL still show IR opcode.
REQ-029 A register read and write to the same index SHALL never coincide, since writes occur only in WB; no bypass is required.
REQ-030 mem_ack while mem_req=0 SHALL be ignored.
REQ-031 Throughput SHALL be 4 cycles per instruction with zero-wait memory (FETCH, WAIT, EXEC, WB).

Reset
REQ-032 When reset_n=0, the block SHALL immediately set: state=FETCH, PC=RESET_PC, IR=0, F1=F2=0, halted=0, mem_req=0, alu_clock=0.
REQ-033 Register file contents SHALL be cleared to 0 on reset.
REQ-034 Reset mid-WAIT SHALL abandon the fetch; a late mem_ack after reset release SHALL be ignored unless mem_req is high.
REQ-035 First mem_req SHALL rise in the first cycle after reset_n deasserts.

Verification
REQ-036 Reset release, mem_ack on first WAIT cycle, word {7'd0,rd=1,rs1=0,rs2=0,...}, alu_C=5 -> R1=5, next mem_addr=1, alu_clock pulsed once.
REQ-037 mem_ack delayed 3 cycles -> mem_req and mem_addr held steady, no alu_clock pulse until after IR capture.
REQ-038 Opcode 8 with alu_F3=1, then opcode 9 with alu_F3=0 -> F1=1,F2=0 after the first, F1=0,F2=1 after the second; no register written.
REQ-039 Opcode 14 with alu_addrch=1, alu_naddr=32'h40 -> next mem_addr=32'h40; with alu_addrch=0 -> PC+1.
REQ-040 PC=32'hFFFF_FFFF, non-branch opcode -> next mem_addr=0.
REQ-041 Opcode 127 -> halted=1, mem_req stays 0 for 20 cycles; reset_n pulse low -> fetch restarts at RESET_PC.
